// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU sequencer.
// SINGLE_STEP_EN adds the STEP_WAIT state.
package cpu_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 13;

  localparam logic [2:0] HALT_OPCODE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
`ifdef SINGLE_STEP_EN
    ,
    S_STEP
`endif
  } state_t;

  function automatic logic is_halt(
    input logic [2:0] op
  );
    return op == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with branch load and
// modulo-2^W increment.
module pc_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_inc,
  output logic [W-1:0] o_pc
);

  logic [W-1:0] r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RST_VAL;
    end else if (i_ld) begin
      r_pc <= i_ld_val;
    end else if (i_inc) begin
      r_pc <= r_pc + W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer.
// SINGLE_STEP_EN gates each retire on step_i.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
`ifdef SINGLE_STEP_EN
  input  logic               step_i,
  output logic               step_wait_o,
`endif
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  input  logic               dec_wr_en_i,
  input  logic               dec_branch_en_i,
  input  logic [PC_W-1:0]    dec_branch_addr_i,
  output logic               alu_en_o,
  output logic               rf_wr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               busy_o,
  output logic               halted_o
);

`ifdef SINGLE_STEP_EN
  localparam state_t S_RETIRE = S_STEP;
`else
  localparam state_t S_RETIRE = S_FETCH;
`endif

  state_t             r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    w_pc;
  logic               w_halt;
  logic               w_pc_ld;
  logic               w_pc_inc;

  assign w_halt = is_halt(r_instr[INSTR_W-1 -: 3]);

  assign w_pc_ld  = (r_state == S_EXEC)
                  && dec_branch_en_i;
  assign w_pc_inc = ((r_state == S_DECODE) && w_halt)
                  || ((r_state == S_EXEC)
                      && !dec_branch_en_i);

  pc_reg #(
    .W       (PC_W),
    .RST_VAL (RESET_PC)
  ) u_pc (
    .i_clk    (clk_i),
    .i_rst_n  (rst_n_i),
    .i_ld     (w_pc_ld),
    .i_ld_val (dec_branch_addr_i),
    .i_inc    (w_pc_inc),
    .o_pc     (w_pc)
  );

`ifdef SINGLE_STEP_EN
  logic r_step_q;
  logic w_step_rise;
  assign w_step_rise = step_i && !r_step_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
`ifdef SINGLE_STEP_EN
      r_step_q <= 1'b0;
`endif
    end else begin
`ifdef SINGLE_STEP_EN
      r_step_q <= step_i;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (start_i) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack_i) begin
            r_instr <= imem_data_i;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= w_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          // branch wins over writeback
          if (dec_branch_en_i)  r_state <= S_RETIRE;
          else if (dec_wr_en_i) r_state <= S_WB;
          else                  r_state <= S_RETIRE;
        end
        S_WB: begin
          r_state <= S_RETIRE;
        end
        S_HALT: begin
          if (start_i) r_state <= S_FETCH;
        end
`ifdef SINGLE_STEP_EN
        S_STEP: begin
          if (w_step_rise) r_state <= S_FETCH;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req_o  = (r_state == S_FETCH);
  assign imem_addr_o = w_pc;
  assign pc_o        = w_pc;
  assign instr_o     = r_instr;
  assign alu_en_o    = (r_state == S_EXEC);
  assign rf_wr_o     = (r_state == S_WB);
  assign halted_o    = (r_state == S_HALT);
  assign busy_o      = (r_state == S_FETCH)
                     || (r_state == S_DECODE)
                     || (r_state == S_EXEC)
                     || (r_state == S_WB);
`ifdef SINGLE_STEP_EN
  assign step_wait_o = (r_state == S_STEP);
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer.
// Events: F=fetch, A=alu_en, B=rf_wr, D=halted.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [12:0] imem_data_i = '0;
  logic [12:0] instr_o;
  logic        dec_wr_en_i;
  logic        dec_branch_en_i;
  logic [7:0]  dec_branch_addr_i;
  logic        alu_en_o;
  logic        rf_wr_o;
  logic [7:0]  pc_o;
  logic        busy_o;
  logic        halted_o;
`ifdef SINGLE_STEP_EN
  logic        step_i = 1'b0;
  logic        step_wait_o;
  bit          step_free = 1'b1;
  bit          step_cmd = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n_i),
    .start_i           (start_i),
`ifdef SINGLE_STEP_EN
    .step_i            (step_i),
    .step_wait_o       (step_wait_o),
`endif
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ack_i        (imem_ack_i),
    .imem_data_i       (imem_data_i),
    .instr_o           (instr_o),
    .dec_wr_en_i       (dec_wr_en_i),
    .dec_branch_en_i   (dec_branch_en_i),
    .dec_branch_addr_i (dec_branch_addr_i),
    .alu_en_o          (alu_en_o),
    .rf_wr_o           (rf_wr_o),
    .pc_o              (pc_o),
    .busy_o            (busy_o),
    .halted_o          (halted_o)
  );

  // toy decoder: op 100 = branch to [7:0], bit 9 = write
  always_comb begin
    dec_branch_en_i   = (instr_o[12:10] == 3'b100);
    dec_branch_addr_i = instr_o[7:0];
    dec_wr_en_i       = instr_o[9];
  end

`ifdef SINGLE_STEP_EN
  always @(posedge clk) begin
    if (step_free) step_i <= ~step_i;
    else           step_i <= step_cmd;
  end
`endif

  int          checks = 0;
  int          fails = 0;
  logic [12:0] mem [256];
  int          delay = 0;
  int          wcnt = 0;
  bit          spur = 1'b0;
  bit          mon_en = 1'b0;
  logic [11:0] q [$];
  int          cyc = 0;
  int          f_cyc = 0;
  int          wait_n = 0;
  bit          in_wait = 1'b0;
  logic [7:0]  w_addr = '0;
  logic [12:0] m_instr = '0;
  logic        prev_halt = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic log_ev(input logic [11:0] ev);
    logic [11:0] e;
    if (q.size() == 0) begin
      chk("unexpected_event", 32'(ev), 32'h0);
    end else begin
      e = q.pop_front();
      chk("event", 32'(ev), 32'(e));
    end
  endtask

  // imem model plus output monitor, both at negedge
  always @(negedge clk) begin
    cyc++;
    if (imem_req_o) begin
      if (wcnt >= delay) begin
        imem_ack_i = 1'b1;
        wcnt = 0;
      end else begin
        imem_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack_i = spur ? 1'($urandom_range(1)) : 1'b0;
      wcnt = 0;
    end
    imem_data_i = mem[imem_addr_o];
    if (mon_en) begin
      if (imem_req_o) begin
        if (!in_wait) begin
          w_addr = imem_addr_o;
          in_wait = 1'b1;
        end else begin
          chk("addr_hold", 32'(imem_addr_o), 32'(w_addr));
        end
        chk("instr_hold", 32'(instr_o), 32'(m_instr));
        if (!imem_ack_i) wait_n++;
      end
      if (imem_req_o && imem_ack_i) begin
        log_ev({4'hF, imem_addr_o});
        chk("wait_cycles", 32'(wait_n), 32'(delay));
        f_cyc = cyc;
      end
      if (alu_en_o) begin
        log_ev({4'hA, pc_o});
        chk("alu_lat", 32'(cyc - f_cyc), 32'd2);
      end
      if (rf_wr_o) begin
        log_ev({4'hB, pc_o});
        chk("wr_lat", 32'(cyc - f_cyc), 32'd3);
      end
      if (halted_o && !prev_halt) begin
        log_ev({4'hD, pc_o});
        chk("halt_lat", 32'(cyc - f_cyc), 32'd2);
      end
    end
    if (imem_req_o && imem_ack_i) begin
      m_instr = imem_data_i;
      in_wait = 1'b0;
      wait_n = 0;
    end
    prev_halt = halted_o;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},    32'(imem_req_o), 32'h0);
    chk({tag, "_alu"},    32'(alu_en_o),   32'h0);
    chk({tag, "_rf"},     32'(rf_wr_o),    32'h0);
    chk({tag, "_busy"},   32'(busy_o),     32'h0);
    chk({tag, "_halted"}, 32'(halted_o),   32'h0);
    chk({tag, "_pc"},     32'(pc_o),       32'h0);
    chk({tag, "_instr"},  32'(instr_o),    32'h0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk_zero(tag);
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    mon_en  = 1'b0;
    m_instr = '0;
    in_wait = 1'b0;
    wait_n  = 0;
    q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      chk({tag, "_timeout"}, 32'(q.size()), 32'h0);
      q.delete();
    end
  endtask

  task automatic push(input logic [3:0] k,
                      input logic [7:0] v);
    q.push_back({k, v});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 13'h0051;
    mem[8'h00] = 13'h0251;
    mem[8'h02] = 13'h1005;
    mem[8'h05] = 13'h1042;
    mem[8'h42] = 13'h0251;
    mem[8'h43] = 13'h1010;
    mem[8'h10] = 13'h1C00;
    mem[8'h11] = 13'h10FF;

    #2;
    apply_reset("rst0");
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy_o), 32'h0);

    // program run: write, plain, branches, halt
    push(4'hF, 8'h00); push(4'hA, 8'h00);
    push(4'hB, 8'h01);
    push(4'hF, 8'h01); push(4'hA, 8'h01);
    push(4'hF, 8'h02); push(4'hA, 8'h02);
    push(4'hF, 8'h05); push(4'hA, 8'h05);
    push(4'hF, 8'h42); push(4'hA, 8'h42);
    push(4'hB, 8'h43);
    push(4'hF, 8'h43); push(4'hA, 8'h43);
    push(4'hF, 8'h10); push(4'hD, 8'h11);
    mon_en = 1'b1;
    pulse_start();
    drain("prog");
    repeat (3) @(posedge clk);
    #1;
    chk("halt_halted", 32'(halted_o), 32'h1);
    chk("halt_busy",   32'(busy_o),   32'h0);
    chk("halt_pc",     32'(pc_o),     32'h11);

    // resume after HALT, branch to 0xFF, wrap to 0x00
    push(4'hF, 8'h11); push(4'hA, 8'h11);
    push(4'hF, 8'hFF); push(4'hA, 8'hFF);
    push(4'hF, 8'h00);
    pulse_start();
    drain("wrap");
    mon_en = 1'b0;

    // slow memory with spurious acks outside FETCH
    apply_reset("rst1");
    delay = 5;
    spur  = 1'b1;
    push(4'hF, 8'h00); push(4'hA, 8'h00);
    push(4'hB, 8'h01); push(4'hF, 8'h01);
    mon_en = 1'b1;
    pulse_start();
    drain("slow");
    mon_en = 1'b0;
    spur   = 1'b0;

    // reset while waiting in FETCH
    apply_reset("rst2");
    pulse_start();
    repeat (2) @(posedge clk);
    #2;
    chk("midfetch_req_pre", 32'(imem_req_o), 32'h1);
    apply_reset("rst_fetch");
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy_o), 32'h0);
    chk("post_rst_req",  32'(imem_req_o), 32'h0);

    // reset during WRITEBACK
    delay = 0;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (rf_wr_o) break;
      @(posedge clk);
      #1;
    end
    chk("wb_reached", 32'(rf_wr_o), 32'h1);
    #2;
    apply_reset("rst_wb");
    repeat (3) @(posedge clk);
    #1;
    chk("post_wb_busy", 32'(busy_o), 32'h0);

    // branch to self loops forever
    mem[8'h00] = 13'h1000;
    for (int i = 0; i < 3; i++) begin
      push(4'hF, 8'h00);
      push(4'hA, 8'h00);
    end
    mon_en = 1'b1;
    pulse_start();
    drain("loop");
    mon_en = 1'b0;
    mem[8'h00] = 13'h0251;

`ifdef SINGLE_STEP_EN
    apply_reset("rst_step");
    step_free = 1'b0;
    step_cmd  = 1'b0;
    repeat (2) @(posedge clk);
    push(4'hF, 8'h00); push(4'hA, 8'h00);
    push(4'hB, 8'h01);
    mon_en = 1'b1;
    pulse_start();
    drain("step0");
    repeat (10) @(posedge clk);
    #1;
    chk("step_wait0", 32'(step_wait_o), 32'h1);
    push(4'hF, 8'h01); push(4'hA, 8'h01);
    step_cmd = 1'b1;
    drain("step1");
    repeat (10) @(posedge clk);
    #1;
    chk("step_wait1", 32'(step_wait_o), 32'h1);
    chk("step_pc",    32'(pc_o),        32'h2);
    mon_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control unit for the 8-bit CPU core. It owns the program counter and fetches 13-bit instructions from instruction memory over a req/ack handshake. It holds the fetched word in an instruction register that feeds the instruction decoder, then uses the decoder's write-enable and branch outputs to sequence ALU capture, register-file writeback and PC update.

Parameters:
PC_W, 8, program counter / instruction address width
INSTR_W, 13, instruction word width
RESET_PC, 0, PC value loaded at reset

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  leave IDLE/HALTED and begin fetching
imem_req_o  out  1  instruction fetch request
imem_addr_o  out  PC_W  fetch address (= pc_o)
imem_ack_i  in  1  fetch data valid this cycle
imem_data_i  in  INSTR_W  fetched instruction
instr_o  out  INSTR_W  instruction register, drives decoder
dec_wr_en_i  in  1  decoder write-enable
dec_branch_en_i  in  1  decoder branch-enable
dec_branch_addr_i  in  PC_W  decoder branch target
alu_en_o  out  1  ALU result-register capture strobe
rf_wr_o  out  1  register-file write strobe
pc_o  out  PC_W  current program counter
busy_o  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
halted_o  out  1  high in HALTED

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE, pc=RESET_PC, instr_o=0, all strobes/busy_o/halted_o=0. Outputs drop immediately, including a pending imem_req_o mid-fetch.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED. All outputs are registered or decoded from the state register; no combinational path from inputs to imem_req_o.
- IDLE: start_i=1 -> FETCH next cycle.
- FETCH: imem_req_o=1; imem_addr_o=pc, stable until ack. On imem_ack_i=1: instr_o<=imem_data_i, -> DECODE. Ack is allowed in the first req cycle; there is no wait-state limit. imem_ack_i outside FETCH is ignored.
- DECODE: one cycle; decoder settles on instr_o.
  - If instr_o[12:10]==3'b111 (HALT): pc<=pc+1, -> HALTED.
  - Else -> EXECUTE.
- EXECUTE: alu_en_o=1 for exactly one cycle.
  - If dec_branch_en_i: pc<=dec_branch_addr_i, -> FETCH.
  - Else pc<=pc+1; -> WRITEBACK if dec_wr_en_i, else -> FETCH.
  - Branch takes priority over wr_en.
- WRITEBACK: rf_wr_o=1 for exactly one cycle, -> FETCH.
- HALTED: halted_o=1; start_i=1 -> FETCH, resuming at the instruction after HALT.
- start_i is ignored while busy.
- Latency with zero-wait ack:
  - ALU+write instruction: 4 cycles.
  - Branch or non-writing instruction: 3 cycles.
  - HALT: 2 cycles.
- PC arithmetic is modulo 2^PC_W: 0xFF+1 -> 0x00. A branch to its own address is legal (tight loop).

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined: adds input step_i and output step_wait_o. After WRITEBACK, or EXECUTE when it returns to FETCH, the FSM enters STEP_WAIT with step_wait_o=1. It proceeds to FETCH only on a step_i rising edge, detected against a registered copy of step_i. Reset clears the edge register.
- Undefined: no extra ports or state; free-running as above.

Decomposition:
- Package cpu_pkg: state enum (3-bit encoding, STEP_WAIT included when enabled), HALT_OPCODE=3'b111, PC_W/INSTR_W defaults.
- Sub-module pc_reg: PC register with load/increment/reset-value inputs.
- FSM stays in cpu_sequencer.

Test Plan:
- Reset then start_i pulse, imem always acks, instr 13'h0251 (ALU, wr) at 0x00 -> req at 0x00; alu_en_o on cycle 3, rf_wr_o on cycle 4; pc_o=0x01; next req at 0x01.
- Branch instr 13'h1042 at 0x05 -> alu_en_o pulses, rf_wr_o never asserts; next imem_addr_o=0x42.
- imem_ack_i delayed 5 cycles -> imem_req_o and imem_addr_o held stable for all 5 cycles; instr_o captures only on the ack cycle.
- HALT 13'h1C00 at 0x10 -> halted_o=1, busy_o=0, pc_o=0x11; start_i -> fetch at 0x11.
- Non-branch instr at pc=0xFF -> pc_o wraps to 0x00; branch to its own address loops indefinitely.
- rst_n_i asserted mid-FETCH and mid-WRITEBACK -> all outputs 0 immediately; pc_o=RESET_PC; FSM IDLE after release until start_i.
- SINGLE_STEP_EN: two instructions, step_i held low -> stall in STEP_WAIT; one step_i rising edge -> exactly one further instruction retires.
